// File: rtl/counter_pkg.sv
// Shared definitions for the button counter.
//   state_e           : FSM encoding for the press / hold / auto-repeat controller
//   SEG_0 .. SEG_9    : active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK         : all segments off, used for non-decimal digit values
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/btn_counter_0_19_if.sv
// Bus between the button counter and its neighbours.
//   btn_clean, clr              : from the debounce stage / control
//   count, bcd_tens, bcd_ones   : counter value, binary and BCD
//   wrap, inc                   : one-cycle event pulses
//   seg_tens, seg_ones          : decoded digits, only when SEG_DECODE_EN is defined
// master = side driving the button/clear, slave = the counter itself.
interface btn_counter_0_19_if;

   logic       btn_clean;
   logic       clr;
   logic [6:0] count;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic       wrap;
   logic       inc;
`ifdef SEG_DECODE_EN
   logic [6:0] seg_tens;
   logic [6:0] seg_ones;

   modport master (
      output btn_clean, clr,
      input  count, bcd_tens, bcd_ones, wrap, inc, seg_tens, seg_ones
   );
   modport slave (
      input  btn_clean, clr,
      output count, bcd_tens, bcd_ones, wrap, inc, seg_tens, seg_ones
   );
`else
   modport master (
      output btn_clean, clr,
      input  count, bcd_tens, bcd_ones, wrap, inc
   );
   modport slave (
      input  btn_clean, clr,
      output count, bcd_tens, bcd_ones, wrap, inc
   );
`endif

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder.
//   digit : 4-bit BCD value
//   seg   : active-low segments {g,f,e,d,c,b,a}; values 10..15 blank the digit
module bcd_to_7seg
   import counter_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/btn_counter_0_19.sv
// Push-button counter 0..MAX_COUNT with hold-to-auto-repeat.
//   clk  : system clock, posedge
//   rst  : synchronous active-high reset
//   bus  : btn_counter_0_19_if.slave (btn_clean, clr in; count, bcd_tens,
//          bcd_ones, wrap, inc out; seg_tens/seg_ones when SEG_DECODE_EN)
// Optional macro SEG_DECODE_EN adds registered seven-segment outputs that
// lag the BCD digits by one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | button released (or held through reset); waiting for a rise
// PRESSED | first increment done; timing the hold delay
// REPEAT  | auto-repeating every REPEAT_CYCLES while held
module btn_counter_0_19
   import counter_pkg::*;
#(
   parameter int MAX_COUNT     = 19,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
)
(
   input  logic              clk,
   input  logic              rst,
   btn_counter_0_19_if.slave bus
);

   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] HOLD_TC = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_TC  = TW'(REPEAT_CYCLES - 1);
   localparam logic [6:0]    MAX_CNT = 7'(MAX_COUNT);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          btn_q, btn_d;
   logic [6:0]    count_q, count_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          inc_q, inc_d;
   logic          wrap_q, wrap_d;
   logic          rise;
   logic          incr;

   assign btn_d = bus.btn_clean;
   assign rise  = bus.btn_clean & ~btn_q;

   // A release always takes precedence over a timer expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      incr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               incr    = 1'b1;
               state_d = PRESSED;
               timer_d = '0;
            end
         end
         PRESSED: begin
            if (!bus.btn_clean) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == HOLD_TC) begin
               incr    = 1'b1;
               state_d = REPEAT;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         REPEAT: begin
            if (!bus.btn_clean) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == REP_TC) begin
               incr    = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // BCD digits count alongside the binary value instead of being divided out.
   // clr only touches the count path, so the FSM keeps auto-repeating.
   always_comb begin
      count_d = count_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      inc_d   = 1'b0;
      wrap_d  = 1'b0;
      if (bus.clr) begin
         count_d = '0;
         tens_d  = '0;
         ones_d  = '0;
      end else if (incr) begin
         inc_d = 1'b1;
         if (count_q == MAX_CNT) begin
            count_d = '0;
            tens_d  = '0;
            ones_d  = '0;
            wrap_d  = 1'b1;
         end else begin
            count_d = count_q + 7'd1;
            if (ones_q == 4'd9) begin
               ones_d = '0;
               tens_d = tens_q + 4'd1;
            end else begin
               ones_d = ones_q + 4'd1;
            end
         end
      end
   end

   // btn_q resets to 1 so a button held through reset is not seen as a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         btn_q   <= 1'b1;
         count_q <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         inc_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         btn_q   <= btn_d;
         count_q <= count_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         inc_q   <= inc_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.bcd_tens = tens_q;
   assign bus.bcd_ones = ones_q;
   assign bus.inc      = inc_q;
   assign bus.wrap     = wrap_q;

`ifdef SEG_DECODE_EN
   logic [6:0] seg_tens_q, seg_tens_d;
   logic [6:0] seg_ones_q, seg_ones_d;

   bcd_to_7seg u_seg_tens (
      .digit (tens_q),
      .seg   (seg_tens_d)
   );

   bcd_to_7seg u_seg_ones (
      .digit (ones_q),
      .seg   (seg_ones_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_tens_q <= SEG_0;
         seg_ones_q <= SEG_0;
      end else begin
         seg_tens_q <= seg_tens_d;
         seg_ones_q <= seg_ones_d;
      end
   end

   assign bus.seg_tens = seg_tens_q;
   assign bus.seg_ones = seg_ones_q;
`endif

endmodule

// File: tb/tb_btn_counter_0_19.sv
// Bench for btn_counter_0_19 (MAX_COUNT=19, HOLD_CYCLES=8, REPEAT_CYCLES=4).
// Reference model tracks how long the button has been held since a real press
// and derives the increment instants arithmetically.
module tb_btn_counter_0_19;

   localparam int MAXC = 19;
   localparam int HOLD = 8;
   localparam int REP  = 4;

   localparam logic [6:0] GLY [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic clk;
   logic rst;

   btn_counter_0_19_if bus ();

   btn_counter_0_19 #(
      .MAX_COUNT     (MAXC),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   int m_prev;
   int m_run;
   int m_count;
   int m_inc;
   int m_wrap;
   logic [6:0] m_seg_t;
   logic [6:0] m_seg_o;

   int inc_seen;
   int wrap_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      if (d >= 0 && d <= 9) return GLY[d];
      return 7'b1111111;
   endfunction

   // Model of one clock edge given the inputs sampled at that edge.
   task automatic model_edge(input logic b, input logic c, input logic r);
      int old;
      bit fire;
      old = m_count;
      if (r) begin
         m_prev  = 1;
         m_run   = -1;
         m_count = 0;
         m_inc   = 0;
         m_wrap  = 0;
         m_seg_t = GLY[0];
         m_seg_o = GLY[0];
      end else begin
         m_seg_t = seg_of(old / 10);
         m_seg_o = seg_of(old % 10);
         if (b && m_prev == 0)      m_run = 0;
         else if (b && m_run >= 0)  m_run = m_run + 1;
         else if (!b)               m_run = -1;
         fire   = (m_run == 0) || (m_run >= HOLD && ((m_run - HOLD) % REP) == 0);
         m_prev = b ? 1 : 0;
         if (c) begin
            m_count = 0;
            m_inc   = 0;
            m_wrap  = 0;
         end else if (fire) begin
            m_inc   = 1;
            m_wrap  = (old == MAXC) ? 1 : 0;
            m_count = (old + 1) % (MAXC + 1);
         end else begin
            m_inc  = 0;
            m_wrap = 0;
         end
      end
   endtask

   task automatic step(input logic b, input logic c, input logic r);
      bus.btn_clean = b;
      bus.clr       = c;
      rst           = r;
      @(posedge clk);
      model_edge(b, c, r);
      #1;
      if (bus.inc === 1'b1)  inc_seen++;
      if (bus.wrap === 1'b1) wrap_seen++;
      chk("count", 32'(bus.count), 32'(m_count));
      chk("bcd_tens", 32'(bus.bcd_tens), 32'(m_count / 10));
      chk("bcd_ones", 32'(bus.bcd_ones), 32'(m_count % 10));
      chk("inc", 32'(bus.inc), 32'(m_inc));
      chk("wrap", 32'(bus.wrap), 32'(m_wrap));
`ifdef SEG_DECODE_EN
      chk("seg_tens", 32'(bus.seg_tens), 32'(m_seg_t));
      chk("seg_ones", 32'(bus.seg_ones), 32'(m_seg_o));
`endif
   endtask

   task automatic press_once();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      inc_seen  = 0;
      wrap_seen = 0;
      m_prev    = 1;
      m_run     = -1;
      m_count   = 0;
      m_inc     = 0;
      m_wrap    = 0;
      m_seg_t   = GLY[0];
      m_seg_o   = GLY[0];

      // Button held through reset: no count until a fresh press.
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      inc_seen = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
      chk("held_thru_rst_inc", 32'(inc_seen), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("first_press_count", 32'(bus.count), 32'd1);

      // Single 3-cycle press.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      inc_seen = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      chk("single_press_incs", 32'(inc_seen), 32'd1);
      chk("single_press_ones", 32'(bus.bcd_ones), 32'd1);

      // Hold 30 cycles: increments at 0, 8, 12, 16, 20, 24, 28.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      inc_seen = 0;
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
      chk("hold_incs", 32'(inc_seen), 32'd7);
      chk("hold_count", 32'(bus.count), 32'd7);
      step(1'b0, 1'b0, 1'b0);

      // BCD carry 9 -> 10 and wrap 19 -> 0.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) press_once();
      step(1'b1, 1'b0, 1'b0);
      chk("carry_tens", 32'(bus.bcd_tens), 32'd1);
      chk("carry_ones", 32'(bus.bcd_ones), 32'd0);
      chk("carry_count", 32'(bus.count), 32'd10);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) press_once();
      wrap_seen = 0;
      step(1'b1, 1'b0, 1'b0);
      chk("wrap_pulse", 32'(bus.wrap), 32'd1);
      chk("wrap_count", 32'(bus.count), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("wrap_once", 32'(wrap_seen), 32'd1);

      // Release exactly on hold-timer expiry: release wins.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      inc_seen = 0;
      for (int i = 0; i < HOLD; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("release_wins_count", 32'(bus.count), 32'd1);
      chk("release_wins_incs", 32'(inc_seen), 32'd1);
      step(1'b1, 1'b0, 1'b0);
      chk("idle_after_release", 32'(bus.count), 32'd2);
      step(1'b0, 1'b0, 1'b0);

      // clr on an auto-repeat edge, repeat continues 4 cycles later.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("clr_count", 32'(bus.count), 32'd0);
      chk("clr_inc", 32'(bus.inc), 32'd0);
      for (int i = 0; i < REP; i++) step(1'b1, 1'b0, 1'b0);
      chk("repeat_after_clr", 32'(bus.count), 32'd1);
      step(1'b0, 1'b0, 1'b0);

      // Randomized button runs with occasional clr and reset.
      for (int n = 0; n < 80; n++) begin
         int len;
         logic b;
         b   = n[0];
         len = $urandom_range(1, 20);
         if ($urandom_range(0, 49) == 0) step(b, 1'b0, 1'b1);
         for (int k = 0; k < len; k++)
            step(b, ($urandom_range(0, 24) == 0), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_counter_0_19.md
Name: btn_counter_0_19

Overview:
Consumes the debounced button level `btn_clean` produced by the upstream `debounce` stage. Each press increments a 0..19 counter, presented as binary and as BCD digits. Holding the button auto-repeats after a hold delay. Sits between `debounce` and the display driver; the display driver consumes the BCD digits.

Parameters:
- MAX_COUNT, 19: terminal count; wraps to 0 after this value; legal range 1..99.
- HOLD_CYCLES, 50_000_000: cycles the button must stay held after the initial increment before the first auto-repeat; must be ≥2.
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat increments; must be ≥2.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- btn_clean, input, 1: debounced button level (1 = pressed), synchronous to clk.
- clr, input, 1: synchronous clear of the count.
- count, output, 7: binary count, 0..MAX_COUNT.
- bcd_tens, output, 4: tens digit of count.
- bcd_ones, output, 4: ones digit of count.
- wrap, output, 1: one-cycle pulse on a MAX_COUNT→0 wrap.
- inc, output, 1: one-cycle pulse on every increment.

Behaviour:
- Reset values:
  - count=0, bcd_tens=0, bcd_ones=0, wrap=0, inc=0.
  - FSM=IDLE, hold timer=0.
  - btn_q (previous btn_clean sample) = 1, so a button held through reset does not count on release of rst.
- Reset mid-operation: everything returns to the reset values on the next edge, regardless of state.
- Edge detection: rise = btn_clean & ~btn_q; btn_q <= btn_clean every cycle.
- FSM states IDLE, PRESSED, REPEAT:
  - IDLE: on rise, assert increment → PRESSED, timer=0. Otherwise stay.
  - PRESSED: if btn_clean=0 → IDLE, timer=0. Else if timer==HOLD_CYCLES-1, assert increment → REPEAT, timer=0. Else timer+1.
  - REPEAT: if btn_clean=0 → IDLE, timer=0. Else if timer==REPEAT_CYCLES-1, assert increment, timer=0. Else timer+1.
- Release priority: a release in the same cycle the timer expires wins; no increment occurs.
- Increment latency: count, BCD digits, inc and wrap all update on the same posedge that first samples the qualifying condition (rise, or timer expiry). They are registered and visible one cycle after the condition is presented.
- Wrap: an increment at count==MAX_COUNT gives count=0, BCD digits=0, wrap=1 for one cycle.
- BCD digits are kept as registered counters, not divided from count:
  - Ones digit wraps 9→0 and carries into the tens digit.
  - bcd_tens*10+bcd_ones == count at all times.
- Pulses: inc and wrap are high for exactly one cycle per increment and zero otherwise.
- Priority on each edge: rst > clr > increment.
  - clr=1 sets count and the BCD digits to 0 and forces inc=0 and wrap=0.
  - clr does not change FSM state or the timer, so auto-repeat continues after clr.
- Timer width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)) bits; no overflow possible.

Optional Feature:
- Macro SEG_DECODE_EN.
- When defined, adds two ports:
  - seg_tens, output, 7: registered decode of bcd_tens.
  - seg_ones, output, 7: registered decode of bcd_ones.
- Segment format: active-low, bit order {g,f,e,d,c,b,a}.
- Timing: one cycle behind the BCD digits; reset value 7'b1000000 (glyph "0").
- Undecoded digit values 10..15 drive all segments off (7'b1111111).
- When not defined, these ports and their logic are absent.

Decomposition:
- Shared package counter_pkg holds:
  - FSM state encoding (IDLE=2'd0, PRESSED=2'd1, REPEAT=2'd2).
  - The seven-segment glyph constants for 0..9, plus SEG_BLANK.
- One natural sub-module: bcd_to_7seg (combinational digit→segments, from the package constants). It is instantiated twice under SEG_DECODE_EN, with the output registers living in btn_counter_0_19.

Test Plan:
All scenarios run with MAX_COUNT=19, HOLD_CYCLES=8, REPEAT_CYCLES=4.
- Reset with btn_clean held 1, then release rst and keep holding for 20 cycles → count stays 0, inc never pulses. Then release, and press again → count=1 one cycle after the press is sampled.
- Single press of 3 cycles, then release → exactly one inc pulse; count=1, bcd_tens=0, bcd_ones=1.
- Hold for 30 cycles from a press at cycle 0 → increments at cycles 0, 8, 12, 16, 20, 24, 28; count=7.
- Start from count=9 and press once → bcd_tens=1, bcd_ones=0, count=10. Start from count=19 and press once → count=0, wrap=1 for one cycle.
- Release the button on exactly the cycle the hold timer reaches 7 → no increment, FSM returns to IDLE.
- Assert clr during REPEAT → count=0 that edge; the next auto-repeat 4 cycles later gives count=1.
- Under SEG_DECODE_EN: count 0→1 gives seg_ones going 7'b1000000→7'b1111001 one cycle after bcd_ones changes.
